byte_arb2: RTL and testbench

BYTE_ARB2 -- requirements
Module: byte_arb2

---
 rtl/byte_pkg.sv | 31 +++
 rtl/byte_rr_arb2.sv | 93 +++++++++
 rtl/byte_arb2.sv | 116 +++++++++++
 tb/tb_byte_arb2.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/byte_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_pkg
//  Description : Shared byte-bus types. Holds the two-way grant encoding used
//                by the arbiter and its wrapper, plus small helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_pkg;

    // Bits per byte lane on the byte bus.
    localparam int C_BYTE_BITS = 8;

    // Which upstream master currently owns the downstream bus.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // Direction of a byte-bus transfer, as seen on an IsWrite strobe.
    typedef enum logic {
        BUS_READ  = 1'b0,
        BUS_WRITE = 1'b1
    } bus_op_e;

    // The master that did not win; round-robin hands priority to it.
    function automatic grant_e other_grant(input grant_e g);
        return (g == GRANT_A) ? GRANT_B : GRANT_A;
    endfunction

endpackage : byte_pkg
`default_nettype wire

// File: rtl/byte_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : byte_rr_arb2
//  Description : Two-way round-robin arbiter with lock. A request stalled by
//                the downstream hold keeps the grant until it is accepted, so
//                the merged address/data stay stable across the stall.
//  Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//                i_a_enable/i_b_enable - master request enables
//                i_mem_hold            - downstream stall
//                o_grant               - selected master
//                o_mem_enable          - merged enable (forced low in reset)
//                o_accept              - request accepted this cycle
//                o_a_hold/o_b_hold     - per-master stall
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_rr_arb2
    import byte_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   i_a_enable,
    input  logic   i_b_enable,
    input  logic   i_mem_hold,
    output grant_e o_grant,
    output logic   o_mem_enable,
    output logic   o_accept,
    output logic   o_a_hold,
    output logic   o_b_hold
);

    grant_e r_prio;
    grant_e r_lock_grant;
    logic   r_locked;

    grant_e w_grant;
    logic   w_grant_en;
    logic   w_mem_enable;
    logic   w_accept;

    // Grant selection: a held request pins the grant; otherwise a lone
    // requester wins and a tie (or idle bus) falls to the priority register.
    always_comb begin
        w_grant = r_prio;
        if (r_locked) begin
            w_grant = r_lock_grant;
        end else if (i_a_enable && !i_b_enable) begin
            w_grant = GRANT_A;
        end else if (i_b_enable && !i_a_enable) begin
            w_grant = GRANT_B;
        end
    end

    always_comb begin
        w_grant_en   = (w_grant == GRANT_A) ? i_a_enable : i_b_enable;
        w_mem_enable = w_grant_en && !rst_i;
        w_accept     = w_mem_enable && !i_mem_hold;
    end

    // Any master that is not the accepted one sees a stall. In reset nothing
    // is accepted, so every requesting master is held.
    always_comb begin
        o_a_hold = i_a_enable;
        o_b_hold = i_b_enable;
        if (!rst_i) begin
            o_a_hold = i_a_enable && ((w_grant != GRANT_A) || i_mem_hold);
            o_b_hold = i_b_enable && ((w_grant != GRANT_B) || i_mem_hold);
        end
    end

    // The lock lives exactly as long as the granted request is both present
    // and stalled; a dropped enable (protocol violation) releases it too.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio       <= GRANT_A;
            r_locked     <= 1'b0;
            r_lock_grant <= GRANT_A;
        end else begin
            r_locked <= w_mem_enable && i_mem_hold;
            if (w_mem_enable && i_mem_hold) begin
                r_lock_grant <= w_grant;
            end
            if (w_accept) begin
                r_prio <= other_grant(w_grant);
            end
        end
    end

    assign o_grant      = w_grant;
    assign o_mem_enable = w_mem_enable;
    assign o_accept     = w_accept;

endmodule : byte_rr_arb2
`default_nettype wire

// File: rtl/byte_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : byte_arb2
//  Description : Merges two byte-bus masters (A, B) onto one downstream port.
//                Arbitration is delegated to byte_rr_arb2; this level muxes
//                the request fields and routes read data back to the master
//                whose read was accepted in the previous cycle.
//  Ports       : clk_i, rst_i                - clock, sync active-high reset
//                a*_i / a*_o                 - master A request / response
//                b*_i / b*_o                 - master B request / response
//                mem*_o                      - merged downstream request
//                memReadData_i, memHold_i    - downstream response / stall
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_arb2
    import byte_pkg::*;
#(
    parameter int DATA_BYTE = 4,
    parameter int ADDR_SIZE = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,

    input  logic                            aEnable_i,
    input  logic                            aIsWrite_i,
    input  logic [DATA_BYTE-1:0]            aWriteMask_i,
    input  logic [ADDR_SIZE-1:0]            aAddr_i,
    input  logic [DATA_BYTE*C_BYTE_BITS-1:0] aWriteData_i,
    output logic [DATA_BYTE*C_BYTE_BITS-1:0] aReadData_o,
    output logic                            aHold_o,

    input  logic                            bEnable_i,
    input  logic                            bIsWrite_i,
    input  logic [DATA_BYTE-1:0]            bWriteMask_i,
    input  logic [ADDR_SIZE-1:0]            bAddr_i,
    input  logic [DATA_BYTE*C_BYTE_BITS-1:0] bWriteData_i,
    output logic [DATA_BYTE*C_BYTE_BITS-1:0] bReadData_o,
    output logic                            bHold_o,

    output logic                            memEnable_o,
    output logic                            memIsWrite_o,
    output logic [DATA_BYTE-1:0]            memWriteMask_o,
    output logic [ADDR_SIZE-1:0]            memAddr_o,
    output logic [DATA_BYTE*C_BYTE_BITS-1:0] memWriteData_o,
    input  logic [DATA_BYTE*C_BYTE_BITS-1:0] memReadData_i,
    input  logic                            memHold_i
);

    localparam int C_DATA_W = DATA_BYTE * C_BYTE_BITS;

    grant_e w_grant;
    logic   w_accept;
    logic   r_rd_valid;
    grant_e r_rd_sel;

    byte_rr_arb2 u_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_a_enable   (aEnable_i),
        .i_b_enable   (bEnable_i),
        .i_mem_hold   (memHold_i),
        .o_grant      (w_grant),
        .o_mem_enable (memEnable_o),
        .o_accept     (w_accept),
        .o_a_hold     (aHold_o),
        .o_b_hold     (bHold_o)
    );

    // Request fields follow the grant combinationally.
    always_comb begin
        memIsWrite_o   = aIsWrite_i;
        memWriteMask_o = aWriteMask_i;
        memAddr_o      = aAddr_i;
        memWriteData_o = aWriteData_i;
        if (w_grant == GRANT_B) begin
            memIsWrite_o   = bIsWrite_i;
            memWriteMask_o = bWriteMask_i;
            memAddr_o      = bAddr_i;
            memWriteData_o = bWriteData_i;
        end
    end

    // Remember who owns the read data returning next cycle. Writes and idle
    // cycles clear the valid so no master ever sees stale data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_valid <= 1'b0;
            r_rd_sel   <= GRANT_A;
        end else begin
            r_rd_valid <= w_accept && (memIsWrite_o == BUS_READ);
            if (w_accept && (memIsWrite_o == BUS_READ)) begin
                r_rd_sel <= w_grant;
            end
        end
    end

    always_comb begin
        aReadData_o = '0;
        bReadData_o = '0;
        if (r_rd_valid) begin
            if (r_rd_sel == GRANT_A) begin
                aReadData_o = memReadData_i;
            end else begin
                bReadData_o = memReadData_i;
            end
        end
    end

    // Keep the derived width visibly tied to the port declarations.
    logic [C_DATA_W-1:0] w_unused_width_ref;
    assign w_unused_width_ref = memReadData_i;
    logic w_unused;
    assign w_unused = ^w_unused_width_ref;

endmodule : byte_arb2
`default_nettype wire

// File: tb/tb_byte_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_arb2
//  Description : Self-checking bench for byte_arb2. Each table row drives one
//                cycle and lists the expected merged enable, grant and holds;
//                read returns are predicted into a queue at acceptance and
//                compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_arb2;

    localparam logic [31:0] C_A_ADDR = 32'h1000_0004;
    localparam logic [31:0] C_B_ADDR = 32'h2000_0008;
    localparam logic [31:0] C_A_WDAT = 32'h1234_5678;
    localparam logic [31:0] C_B_WDAT = 32'hCAFE_F00D;
    localparam logic [3:0]  C_A_MASK = 4'b0011;
    localparam logic [3:0]  C_B_MASK = 4'b1100;
    localparam int          C_NVEC   = 23;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        aEnable_i = 1'b0, aIsWrite_i = 1'b0;
    logic [3:0]  aWriteMask_i = C_A_MASK;
    logic [31:0] aAddr_i = C_A_ADDR, aWriteData_i = C_A_WDAT;
    logic [31:0] aReadData_o;
    logic        aHold_o;
    logic        bEnable_i = 1'b0, bIsWrite_i = 1'b0;
    logic [3:0]  bWriteMask_i = C_B_MASK;
    logic [31:0] bAddr_i = C_B_ADDR, bWriteData_i = C_B_WDAT;
    logic [31:0] bReadData_o;
    logic        bHold_o;
    logic        memEnable_o, memIsWrite_o;
    logic [3:0]  memWriteMask_o;
    logic [31:0] memAddr_o, memWriteData_o;
    logic [31:0] memReadData_i = '0;
    logic        memHold_i = 1'b0;

    byte_arb2 #(.DATA_BYTE(4), .ADDR_SIZE(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aEnable_i(aEnable_i), .aIsWrite_i(aIsWrite_i), .aWriteMask_i(aWriteMask_i),
        .aAddr_i(aAddr_i), .aWriteData_i(aWriteData_i),
        .aReadData_o(aReadData_o), .aHold_o(aHold_o),
        .bEnable_i(bEnable_i), .bIsWrite_i(bIsWrite_i), .bWriteMask_i(bWriteMask_i),
        .bAddr_i(bAddr_i), .bWriteData_i(bWriteData_i),
        .bReadData_o(bReadData_o), .bHold_o(bHold_o),
        .memEnable_o(memEnable_o), .memIsWrite_o(memIsWrite_o),
        .memWriteMask_o(memWriteMask_o), .memAddr_o(memAddr_o),
        .memWriteData_o(memWriteData_o), .memReadData_i(memReadData_i),
        .memHold_i(memHold_i)
    );

    always #5 clk_i = ~clk_i;

    // eg: expected grant, 0 = A, 1 = B, 2 = not checked (reset rows).
    typedef struct {
        bit rst, aen, awr, ben, bwr, hold;
        int eg;
        bit een, eah, ebh;
    } vec_t;

    typedef struct {
        bit valid;
        bit sel_b;
    } rd_exp_t;

    vec_t    vecs[C_NVEC];
    rd_exp_t sb[$];
    int      n_vec  = 0;
    int      n_fail = 0;

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    initial begin
        //          rst aen awr ben bwr hold eg een eah ebh
        vecs[0]  = '{1, 1, 0, 1, 0, 0,  2, 0, 1, 1};  // reset: holds = enables
        vecs[1]  = '{1, 0, 0, 0, 0, 0,  2, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0,  0, 1, 0, 0};  // lone A read
        vecs[3]  = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0};  // A sees DEADBEEF
        vecs[4]  = '{1, 0, 0, 0, 0, 0,  2, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 1, 0, 0,  0, 1, 0, 1};  // alternate A,B,A,B
        vecs[6]  = '{0, 1, 0, 1, 0, 0,  1, 1, 1, 0};
        vecs[7]  = '{0, 1, 0, 1, 0, 0,  0, 1, 0, 1};
        vecs[8]  = '{0, 1, 0, 1, 0, 0,  1, 1, 1, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 1,  1, 1, 0, 1};  // B stalls, locks
        vecs[10] = '{0, 1, 0, 1, 0, 1,  1, 1, 1, 1};  // locked on B
        vecs[11] = '{0, 1, 0, 1, 0, 1,  1, 1, 1, 1};
        vecs[12] = '{0, 1, 0, 1, 0, 0,  1, 1, 1, 0};  // B accepted
        vecs[13] = '{0, 1, 1, 1, 0, 0,  0, 1, 0, 1};  // A write accepted
        vecs[14] = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0};  // no read data
        vecs[15] = '{0, 1, 0, 0, 0, 1,  0, 1, 1, 0};  // A locks
        vecs[16] = '{1, 1, 0, 1, 0, 1,  2, 0, 1, 1};  // reset while locked
        vecs[17] = '{0, 1, 0, 1, 0, 0,  0, 1, 0, 1};  // A first, no stale data
        vecs[18] = '{0, 0, 0, 1, 0, 1,  1, 1, 0, 1};  // B locks
        vecs[19] = '{0, 1, 0, 0, 0, 1,  1, 0, 1, 0};  // B drops enable
        vecs[20] = '{0, 1, 0, 0, 0, 0,  0, 1, 0, 0};  // lock gone, A wins
        vecs[21] = '{0, 0, 0, 1, 1, 0,  1, 1, 0, 0};  // B write
        vecs[22] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0};

        for (int i = 0; i < C_NVEC; i++) begin
            logic [31:0] md;
            logic        gwr;
            rd_exp_t     e;
            @(posedge clk_i);
            #1;
            md = (i == 3) ? 32'hDEAD_BEEF : $urandom;
            rst_i         = vecs[i].rst;
            aEnable_i     = vecs[i].aen;
            aIsWrite_i    = vecs[i].awr;
            bEnable_i     = vecs[i].ben;
            bIsWrite_i    = vecs[i].bwr;
            memHold_i     = vecs[i].hold;
            memReadData_i = md;
            #1;
            check("memEnable", i, {31'd0, memEnable_o}, {31'd0, vecs[i].een});
            check("aHold",     i, {31'd0, aHold_o},     {31'd0, vecs[i].eah});
            check("bHold",     i, {31'd0, bHold_o},     {31'd0, vecs[i].ebh});
            gwr = (vecs[i].eg == 1) ? vecs[i].bwr : vecs[i].awr;
            if (vecs[i].eg != 2) begin
                check("memAddr",    i, memAddr_o,
                      (vecs[i].eg == 1) ? C_B_ADDR : C_A_ADDR);
                check("memIsWrite", i, {31'd0, memIsWrite_o}, {31'd0, gwr});
                check("memMask",    i, {28'd0, memWriteMask_o},
                      {28'd0, (vecs[i].eg == 1) ? C_B_MASK : C_A_MASK});
                check("memWdata",   i, memWriteData_o,
                      (vecs[i].eg == 1) ? C_B_WDAT : C_A_WDAT);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("aReadData", i, aReadData_o,
                      (e.valid && !e.sel_b) ? md : 32'd0);
                check("bReadData", i, bReadData_o,
                      (e.valid && e.sel_b) ? md : 32'd0);
            end
            e.valid = vecs[i].een && !vecs[i].hold && !gwr;
            e.sel_b = (vecs[i].eg == 1);
            sb.push_back(e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_byte_arb2
`default_nettype wire
